multicycle_ctrl: RTL

- Multi-cycle sequencer for the RV32I core datapath.
- Walks each instruction through the FETCH, DECODE, EXEC, MEM and WB states.
- Drives the immediate-type select, PC update, register write and memory request strobes.
- Handshakes with variable-latency instruction and data memories, detects illegal opcodes and bus timeouts, and enters a sticky trap state on either.

---
 rtl/multicycle_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on illegal opcode or bus timeout.
// Latency: 3 (branch), 4 (store/ALU/jumps) or 5 (load) cycles with zero-wait acks; strobes are combinational.
// Backpressure: imem_req/dmem_req are held until the matching ack; TIMEOUT unacked request cycles trap.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [2:0] imm_sel,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       trap
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b101;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       imm_dec;
    logic             op_legal;
    logic             timeout_hit;
    logic             wait_cyc;

    always_comb begin
        imm_dec  = IMM_NONE;
        op_legal = 1'b1;
        case (opcode)
            OP_IALU, OP_LOAD, OP_JALR: imm_dec = IMM_I;
            OP_STORE:                  imm_dec = IMM_S;
            OP_BRANCH:                 imm_dec = IMM_B;
            OP_AUIPC, OP_LUI:          imm_dec = IMM_U;
            OP_JAL:                    imm_dec = IMM_J;
            OP_R:                      imm_dec = IMM_NONE;
            default:                   op_legal = 1'b0;
        endcase
    end

    // The last allowed request cycle is the one where the counter reads TIMEOUT-1.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);
    assign wait_cyc    = ((state == FETCH) && !imem_ack) || ((state == MEM) && !dmem_ack);

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        imm_sel   = IMM_NONE;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        retire    = 1'b0;
        trap      = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = DECODE;
                end else if (timeout_hit) begin
                    state_nxt = TRAP;
                end
            end
            DECODE: state_nxt = op_legal ? EXEC : TRAP;
            EXEC: begin
                if (opcode == OP_BRANCH) begin
                    pc_we     = 1'b1;
                    pc_src    = br_taken ? 2'b01 : 2'b00;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ack) begin
                    if (opcode == OP_STORE) begin
                        pc_we     = 1'b1;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (timeout_hit) begin
                    state_nxt = TRAP;
                end
            end
            WB: begin
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_nxt = FETCH;
                case (opcode)
                    OP_LOAD:         wb_sel = 2'b01;
                    OP_JAL, OP_JALR: wb_sel = 2'b10;
                    OP_LUI:          wb_sel = 2'b11;
                    default:         wb_sel = 2'b00;
                endcase
                if (opcode == OP_JAL)       pc_src = 2'b01;
                else if (opcode == OP_JALR) pc_src = 2'b10;
            end
            TRAP:    trap = 1'b1;
            default: state_nxt = FETCH;
        endcase
        if (state == DECODE || state == EXEC || state == MEM || state == WB) imm_sel = imm_dec;
        // Reset kills every strobe combinationally so an aborted instruction never commits.
        if (!rst_n) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            imm_sel  = IMM_NONE;
            pc_we    = 1'b0;
            pc_src   = 2'b00;
            reg_we   = 1'b0;
            wb_sel   = 2'b00;
            retire   = 1'b0;
            trap     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (TIMEOUT_EN && wait_cyc)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
endmodule
